// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave front end: ID/control/alert/scratch registers
// plus saturating goodCRC and illegal-access counters, with a one-access-per-request handshake.
module i2c_reg_bank #(
    parameter logic [15:0] VENDOR_ID  = 16'h1234,
    parameter logic [15:0] PRODUCT_ID = 16'h0001,
    parameter logic [6:0]  DEV_ADDR   = 7'h2A
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  ADDR,
    input  logic        RNW,
    input  logic        req,
    input  logic [15:0] WR_DATA,
    input  logic        goodCRC,
    input  logic [15:0] evt_in,
    output logic [15:0] RD_DATA,
    output logic        ack,
    output logic        err,
    output logic        alert_n,
    output logic [15:0] ctrl_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t      state;
    logic [15:0] control;
    logic [15:0] alert;
    logic [15:0] alertMask;
    logic [15:0] crcCount;
    logic [15:0] errCount;
    logic [15:0] scratch [8];

    logic        inRange;
    logic [3:0]  idx;
    logic        accept;
    logic        illegal;
    logic        legalWrite;
    logic [15:0] w1cMask;

    assign inRange    = (ADDR[7:4] == 4'h0);
    assign idx        = ADDR[3:0];
    assign accept     = (state == IDLE) && req;
    // Writes to the read-only ID registers and anything outside the map are rejected.
    assign illegal    = accept && (!inRange || (!RNW && (idx < 4'd3)));
    assign legalWrite = accept && !RNW && !illegal;
    assign w1cMask    = (legalWrite && idx == 4'd4) ? WR_DATA : 16'h0000;
    assign ctrl_out   = control;

    always_comb begin
        RD_DATA = 16'h0000;
        if (inRange) begin
            if (idx[3]) begin
                RD_DATA = scratch[idx[2:0]];
            end else begin
                case (idx[2:0])
                    3'd0: RD_DATA = VENDOR_ID;
                    3'd1: RD_DATA = PRODUCT_ID;
                    3'd2: RD_DATA = {9'b0, DEV_ADDR};
                    3'd3: RD_DATA = control;
                    3'd4: RD_DATA = alert;
                    3'd5: RD_DATA = alertMask;
                    3'd6: RD_DATA = crcCount;
                    3'd7: RD_DATA = errCount;
                    default: RD_DATA = 16'h0000;
                endcase
            end
        end
    end

    // Reset parks in HOLD so a request left high across reset is ignored until it drops.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= HOLD;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack <= accept;
            err <= illegal;
            case (state)
                IDLE:    if (req) state <= HOLD;
                HOLD:    if (!req) state <= IDLE;
                default: state <= HOLD;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            control   <= 16'h0000;
            alertMask <= 16'hFFFF;
            for (int i = 0; i < 8; i++) scratch[i] <= 16'h0000;
        end else if (legalWrite) begin
            if (idx[3]) scratch[idx[2:0]] <= WR_DATA;
            else if (idx == 4'd3) control <= WR_DATA;
            else if (idx == 4'd5) alertMask <= WR_DATA;
        end
    end

    // Incoming events are OR-ed in after the clear, so a set beats a simultaneous W1C.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            alert   <= 16'h0000;
            alert_n <= 1'b1;
        end else begin
            alert   <= (alert & ~w1cMask) | evt_in;
            alert_n <= ~|(alert & alertMask);
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            crcCount <= 16'h0000;
            errCount <= 16'h0000;
        end else begin
            if (legalWrite && idx == 4'd6) begin
                crcCount <= goodCRC ? 16'h0001 : 16'h0000;
            end else if (goodCRC && crcCount != 16'hFFFF) begin
                crcCount <= crcCount + 16'd1;
            end
            if (legalWrite && idx == 4'd7) begin
                errCount <= 16'h0000;
            end else if (illegal && errCount != 16'hFFFF) begin
                errCount <= errCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed, table-driven bench for i2c_reg_bank with hand-computed expectations
// plus hand-written sequences for alert, CRC saturation and reset-during-access.
module tb_i2c_reg_bank;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  ADDR;
    logic        RNW;
    logic        req;
    logic [15:0] WR_DATA;
    logic        goodCRC;
    logic [15:0] evt_in;
    logic [15:0] RD_DATA;
    logic        ack;
    logic        err;
    logic        alert_n;
    logic [15:0] ctrl_out;

    int assertCount = 0;
    int failCount   = 0;
    int ackCnt;
    int errCnt;

    typedef struct {
        logic [7:0]  addr;
        logic        rnw;
        logic [15:0] wdata;
        int          hold;
        int          expAcks;
        int          expErrs;
        logic [7:0]  chkAddr;
        logic [15:0] expRd;
        logic [15:0] expCtrl;
    } vec_t;

    vec_t vecs [16];

    i2c_reg_bank dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .ADDR     (ADDR),
        .RNW      (RNW),
        .req      (req),
        .WR_DATA  (WR_DATA),
        .goodCRC  (goodCRC),
        .evt_in   (evt_in),
        .RD_DATA  (RD_DATA),
        .ack      (ack),
        .err      (err),
        .alert_n  (alert_n),
        .ctrl_out (ctrl_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic readCheck(input string name, input logic [7:0] addr, input logic [15:0] expected);
        ADDR = addr;
        #1;
        checkOutput(name, RD_DATA, expected);
    endtask

    // Holds req for 'hold' cycles, then one low cycle; counts ack/err pulses seen.
    task automatic applyStimulus(input logic [7:0] addr, input logic rnw, input logic [15:0] wdata, input int hold);
        ackCnt = 0;
        errCnt = 0;
        ADDR    = addr;
        RNW     = rnw;
        WR_DATA = wdata;
        req     = 1'b1;
        repeat (hold) begin
            tick();
            if (ack) ackCnt++;
            if (err) errCnt++;
        end
        req = 1'b0;
        tick();
        if (ack) ackCnt++;
        if (err) errCnt++;
    endtask

    initial begin
        vecs[0]  = '{8'h03, 1'b0, 16'hBEEF, 5, 1, 0, 8'h03, 16'hBEEF, 16'hBEEF};
        vecs[1]  = '{8'h07, 1'b1, 16'h0000, 1, 1, 0, 8'h07, 16'h0000, 16'hBEEF};
        vecs[2]  = '{8'h03, 1'b0, 16'h0001, 1, 1, 0, 8'h03, 16'h0001, 16'h0001};
        vecs[3]  = '{8'h01, 1'b0, 16'h5555, 2, 1, 1, 8'h01, 16'h0001, 16'h0001};
        vecs[4]  = '{8'h07, 1'b1, 16'h0000, 1, 1, 0, 8'h07, 16'h0001, 16'h0001};
        vecs[5]  = '{8'h07, 1'b0, 16'h0000, 1, 1, 0, 8'h07, 16'h0000, 16'h0001};
        vecs[6]  = '{8'h40, 1'b1, 16'h0000, 1, 1, 1, 8'h07, 16'h0001, 16'h0001};
        vecs[7]  = '{8'h07, 1'b0, 16'h1234, 1, 1, 0, 8'h07, 16'h0000, 16'h0001};
        vecs[8]  = '{8'h08, 1'b0, 16'hA5A5, 1, 1, 0, 8'h08, 16'hA5A5, 16'h0001};
        vecs[9]  = '{8'h0F, 1'b0, 16'h1234, 3, 1, 0, 8'h0F, 16'h1234, 16'h0001};
        vecs[10] = '{8'h05, 1'b0, 16'h00F0, 1, 1, 0, 8'h05, 16'h00F0, 16'h0001};
        vecs[11] = '{8'h00, 1'b0, 16'hFFFF, 1, 1, 1, 8'h00, 16'h1234, 16'h0001};
        vecs[12] = '{8'h02, 1'b0, 16'h0000, 1, 1, 1, 8'h02, 16'h002A, 16'h0001};
        vecs[13] = '{8'h17, 1'b0, 16'h0000, 1, 1, 1, 8'h07, 16'h0003, 16'h0001};
        vecs[14] = '{8'h05, 1'b0, 16'hFFFF, 1, 1, 0, 8'h05, 16'hFFFF, 16'h0001};
        vecs[15] = '{8'h08, 1'b1, 16'h0000, 1, 1, 0, 8'h08, 16'hA5A5, 16'h0001};

        Reset   = 1'b0;
        ADDR    = 8'h00;
        RNW     = 1'b1;
        req     = 1'b0;
        WR_DATA = 16'h0000;
        goodCRC = 1'b0;
        evt_in  = 16'h0000;
        repeat (2) tick();
        checkOutput("rst_ack", {15'b0, ack}, 16'h0000);
        checkOutput("rst_err", {15'b0, err}, 16'h0000);
        checkOutput("rst_alert_n", {15'b0, alert_n}, 16'h0001);
        checkOutput("rst_ctrl", ctrl_out, 16'h0000);
        Reset = 1'b1;
        tick();
        readCheck("rd_devid", 8'h02, 16'h002A);
        readCheck("rd_vendor", 8'h00, 16'h1234);
        readCheck("rd_mask_rst", 8'h05, 16'hFFFF);
        readCheck("rd_oob", 8'h40, 16'h0000);
        tick();
        checkOutput("no_req_ack", {15'b0, ack}, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].rnw, vecs[i].wdata, vecs[i].hold);
            checkOutput($sformatf("v%0d_acks", i), 16'(ackCnt), 16'(vecs[i].expAcks));
            checkOutput($sformatf("v%0d_errs", i), 16'(errCnt), 16'(vecs[i].expErrs));
            checkOutput($sformatf("v%0d_ctrl", i), ctrl_out, vecs[i].expCtrl);
            readCheck($sformatf("v%0d_rd", i), vecs[i].chkAddr, vecs[i].expRd);
        end

        // Alert set, then one-cycle lag on alert_n.
        applyStimulus(8'h07, 1'b0, 16'h0000, 1);
        evt_in = 16'h0003;
        tick();
        evt_in = 16'h0000;
        readCheck("alert_set", 8'h04, 16'h0003);
        checkOutput("alert_n_lag", {15'b0, alert_n}, 16'h0001);
        tick();
        checkOutput("alert_n_low", {15'b0, alert_n}, 16'h0000);

        // W1C of bit 0 collides with a new event on bit 0: set wins.
        ADDR    = 8'h04;
        RNW     = 1'b0;
        WR_DATA = 16'h0001;
        req     = 1'b1;
        evt_in  = 16'h0001;
        tick();
        evt_in = 16'h0000;
        req    = 1'b0;
        checkOutput("w1c_ack", {15'b0, ack}, 16'h0001);
        readCheck("w1c_vs_set", 8'h04, 16'h0003);
        tick();
        applyStimulus(8'h04, 1'b0, 16'h0002, 1);
        readCheck("w1c_bit1", 8'h04, 16'h0001);
        applyStimulus(8'h05, 1'b0, 16'h0000, 1);
        checkOutput("alert_n_masked", {15'b0, alert_n}, 16'h0001);
        readCheck("alert_kept", 8'h04, 16'h0001);
        applyStimulus(8'h04, 1'b0, 16'hFFFF, 1);
        readCheck("alert_clr", 8'h04, 16'h0000);

        // goodCRC counting, clear-with-pulse, and saturation.
        goodCRC = 1'b1;
        repeat (3) tick();
        goodCRC = 1'b0;
        readCheck("crc_3", 8'h06, 16'h0003);
        ADDR    = 8'h06;
        RNW     = 1'b0;
        WR_DATA = 16'h0000;
        req     = 1'b1;
        goodCRC = 1'b1;
        tick();
        goodCRC = 1'b0;
        req     = 1'b0;
        readCheck("crc_clr_pulse", 8'h06, 16'h0001);
        tick();
        goodCRC = 1'b1;
        repeat (65533) tick();
        goodCRC = 1'b0;
        readCheck("crc_fffe", 8'h06, 16'hFFFE);
        goodCRC = 1'b1;
        repeat (3) tick();
        goodCRC = 1'b0;
        readCheck("crc_sat", 8'h06, 16'hFFFF);

        // Reset in the middle of a held access.
        applyStimulus(8'h08, 1'b0, 16'h1111, 1);
        readCheck("scr0_set", 8'h08, 16'h1111);
        WR_DATA = 16'h2222;
        RNW     = 1'b0;
        req     = 1'b1;
        Reset   = 1'b0;
        tick();
        Reset = 1'b1;
        checkOutput("midrst_ack", {15'b0, ack}, 16'h0000);
        readCheck("midrst_scr0", 8'h08, 16'h0000);
        readCheck("midrst_crc", 8'h06, 16'h0000);
        ADDR    = 8'h08;
        WR_DATA = 16'h3333;
        ackCnt  = 0;
        repeat (3) begin
            tick();
            if (ack) ackCnt++;
        end
        checkOutput("held_req_ignored", 16'(ackCnt), 16'h0000);
        readCheck("held_scr0", 8'h08, 16'h0000);
        req = 1'b0;
        tick();
        applyStimulus(8'h08, 1'b0, 16'h3333, 1);
        checkOutput("rereq_ack", 16'(ackCnt), 16'h0001);
        readCheck("rereq_scr0", 8'h08, 16'h3333);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
